// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Instruction store and boot sequencer for the 4-bit CPU. A program arrives
// as a valid/ready stream of words and is written into a DEPTH-entry store.
// Any locations after the program are padded with FILL_WORD (HLT). The CPU is
// held in reset until the store is fully consistent. The CPU fetches through
// a combinational read port indexed by its program counter.
//
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to enable the CHK/ERR
// states. The payload is then followed by one extra stream word that must
// equal the XOR of all payload words; a mismatch parks the loader in ERR.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high
//   load_req    in   one-cycle request to (re)load a program
//   load_len    in   payload word count minus 1, sampled with load_req
//   in_valid    in   stream word valid
//   in_data     in   stream word
//   in_ready    out  loader accepts in_data this cycle
//   fetch_addr  in   CPU program counter
//   fetch_data  out  store contents at fetch_addr (combinational)
//   cpu_reset   out  CPU reset; high whenever the store is not runnable
//   busy        out  high in LOAD, CHK or FILL
//   done        out  one-cycle pulse on entry to RUN
//   err         out  checksum mismatch, held while in ERR
//   checksum    out  running XOR of accepted payload words
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int                DEPTH     = 16,  // must equal 2**ADDR_W
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] FILL_WORD = 4'b1110
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_CHK,
    ST_FILL,
    ST_RUN,
    ST_ERR
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] csum;
  logic              done_q;

  logic [DATA_W-1:0] store [DEPTH];

  logic              we;
  logic [DATA_W-1:0] wdata;

  logic accept;
  logic last_word;
  logic len_full;
  logic idle_state;

  assign accept     = in_valid & in_ready;
  assign last_word  = (wa == len);
  assign len_full   = (len == LAST_ADDR);
  // States from which a new load may be started; load_req is ignored otherwise.
  assign idle_state = (state == ST_EMPTY) || (state == ST_RUN) || (state == ST_ERR);

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_EMPTY;
      len    <= '0;
      wa     <= '0;
      csum   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      // done is high for exactly the first cycle spent in RUN.
      done_q <= (next_state == ST_RUN) && (state != ST_RUN);

      if (idle_state && load_req) begin
        len  <= load_len;
        wa   <= '0;
        csum <= '0;
      end else if (state == ST_LOAD && accept) begin
        csum <= csum ^ in_data;
        wa   <= wa + 1'b1;
      end else if (state == ST_FILL) begin
        wa   <= wa + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would otherwise infer a latch.
    next_state = state;
    case (state)
      ST_EMPTY, ST_RUN: begin
        if (load_req) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          next_state = ST_CHK;
`else
          // A full-length program leaves nothing to pad.
          next_state = len_full ? ST_RUN : ST_FILL;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        // csum already includes the last payload word at this point.
        if (accept) begin
          if (in_data == csum) next_state = len_full ? ST_RUN : ST_FILL;
          else                 next_state = ST_ERR;
        end
      end
      ST_ERR: begin
        if (load_req) next_state = ST_LOAD;
      end
`endif
      ST_FILL: begin
        // The write at the last address happens on this same edge.
        if (wa == LAST_ADDR) next_state = ST_RUN;
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output and write-port decode
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    cpu_reset = 1'b1;
    err       = 1'b0;
    we        = 1'b0;
    wdata     = FILL_WORD;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        we       = in_valid;
        wdata    = in_data;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_ERR: begin
        err = 1'b1;
      end
`endif
      ST_FILL: begin
        busy  = 1'b1;
        we    = 1'b1;
        wdata = FILL_WORD;
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
      end
      default: ;
    endcase
    // A reset edge aborts the load without touching the store.
    if (reset) we = 1'b0;
  end

  assign done     = done_q;
  assign checksum = csum;

  // -------------------------------------------------------------------------
  // Instruction store
  // -------------------------------------------------------------------------
  // NOTE: the store array is deliberately not reset; it maps onto plain RAM
  // and reset only has to keep the CPU from running stale contents, which
  // cpu_reset already guarantees.
  always_ff @(posedge clk) begin
    if (we) store[wa] <= wdata;
  end

  // Asynchronous read: a write in the same cycle is seen only after the edge.
  assign fetch_data = store[fetch_addr];

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req;
  logic [3:0] load_len;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] fetch_addr;
  logic [3:0] fetch_data;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] checksum;

  int checks   = 0;
  int failures = 0;

  logic [3:0] prog [16];
  int         edges;

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [3:0] len);
    load_req = 1'b1;
    load_len = len;
    tick();
    load_req = 1'b0;
  endtask

  // Present one word and hold it until the edge that accepts it.
  task automatic send_word(input logic [3:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [3:0] xor_of(input int len);
    logic [3:0] x = 4'h0;
    for (int i = 0; i <= len; i++) x ^= prog[i];
    return x;
  endfunction

  // Trailing checksum word, only consumed when the check is built in.
  task automatic send_trailer(input logic [3:0] w);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_word(w);
`else
    if (w === 4'hx) in_valid = 1'b0;
`endif
  endtask

  // Count edges from the last accept until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic check_store(input string tag, input int len);
    for (int i = 0; i < 16; i++) begin
      fetch_addr = 4'(i);
      tick();
      check($sformatf("%s_store%0d", tag, i), fetch_data,
            (i <= len) ? prog[i] : 4'hE);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    load_req   = 1'b0;
    load_len   = 4'h0;
    in_valid   = 1'b0;
    in_data    = 4'h0;
    fetch_addr = 4'h0;
    tick();
    tick();
    reset = 1'b0;

    // ---- idle after reset -------------------------------------------------
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle%0d_flags", i), {cpu_reset, busy, in_ready, done, err}, 5'b10000);
    end
    check("idle_checksum", checksum, 4'h0);

    // ---- len=2, payload 1,3,5 back-to-back --------------------------------
    prog[0] = 4'h1; prog[1] = 4'h3; prog[2] = 4'h5;
    start_load(4'd2);
    check("load_busy_ready", {busy, in_ready, cpu_reset}, 3'b111);
    send_word(4'h1);
    send_word(4'h3);
    send_word(4'h5);
    send_trailer(4'h7);
    check("len2_fill_busy", busy, 1'b1);
    wait_done(edges);
    check("len2_done_latency", edges, 13);
    check("len2_cpu_reset", cpu_reset, 1'b0);
    tick();
    check("len2_done_pulse", done, 1'b0);
    check("len2_checksum", checksum, 4'h7);
    check("len2_run_cpu_reset", cpu_reset, 1'b0);
    check_store("len2", 2);

    // ---- len=15, in_valid toggling, no FILL -------------------------------
    for (int i = 0; i < 16; i++) prog[i] = 4'((i * 3 + 1) % 16);
    start_load(4'd15);
    for (int i = 0; i < 16; i++) begin
      send_word(prog[i]);
      if (i < 15) begin
        tick();
        check($sformatf("len15_gap%0d_done", i), done, 1'b0);
      end
    end
    send_trailer(xor_of(15));
    wait_done(edges);
    check("len15_done_latency", edges, 0);
    check("len15_busy", busy, 1'b0);
    check("len15_checksum", checksum, xor_of(15));
    check_store("len15", 15);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // ---- checksum mismatch then match -------------------------------------
    prog[0] = 4'h6; prog[1] = 4'h3;
    start_load(4'd1);
    send_word(4'h6);
    send_word(4'h3);
    send_word(4'h4);
    check("chk_bad_err", err, 1'b1);
    check("chk_bad_flags", {cpu_reset, busy, in_ready}, 3'b100);
    repeat (3) tick();
    check("chk_bad_sticky", {err, cpu_reset}, 2'b11);
    start_load(4'd1);
    check("chk_reload_err_clr", err, 1'b0);
    send_word(4'h6);
    send_word(4'h3);
    send_word(4'h5);
    wait_done(edges);
    check("chk_good_latency", edges, 14);
    check("chk_good_flags", {err, cpu_reset}, 2'b00);
    check_store("chk", 1);
`endif

    // ---- reset on the 2nd accepted word -----------------------------------
    start_load(4'd3);
    send_word(4'hF);
    in_valid = 1'b1;
    in_data  = 4'h0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_mid_flags", {cpu_reset, busy, in_ready, done}, 4'b1000);
    check("rst_mid_checksum", checksum, 4'h0);
    prog[0] = 4'h9; prog[1] = 4'h8; prog[2] = 4'h7; prog[3] = 4'h2;
    start_load(4'd3);
    for (int i = 0; i < 4; i++) send_word(prog[i]);
    send_trailer(xor_of(3));
    wait_done(edges);
    check("rst_reload_latency", edges, 12);
    check("rst_reload_checksum", checksum, 4'h4);
    check_store("rst_reload", 3);

    // ---- load_req mid-LOAD is ignored --------------------------------------
    prog[0] = 4'hC; prog[1] = 4'hD; prog[2] = 4'hA; prog[3] = 4'h5;
    start_load(4'd3);
    send_word(4'hC);
    load_req = 1'b1;
    load_len = 4'd0;
    send_word(4'hD);
    load_req = 1'b0;
    check("ign_busy_ready", {busy, in_ready}, 2'b11);
    check("ign_checksum", checksum, 4'h1);
    send_word(4'hA);
    send_word(4'h5);
    send_trailer(xor_of(3));
    wait_done(edges);
    check("ign_latency", edges, 12);
    check_store("ign", 3);

    // ---- load_req in RUN restarts at address 0 -----------------------------
    start_load(4'd0);
    check("rerun_flags", {cpu_reset, busy, done}, 3'b110);
    prog[0] = 4'hB;
    send_word(4'hB);
    fetch_addr = 4'h0;
    #1;
    check("rerun_word0_visible", fetch_data, 4'hB);
    send_trailer(4'hB);
    wait_done(edges);
    check("rerun_latency", edges, 15);
    check_store("rerun", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
